// File: rtl/eth_rx_filter_pack.sv
// eth_rx_filter_pack: destination-MAC filter and 8->32 packer for the rx stream.
// Words are queued in a show-ahead FIFO; overflow truncates with an error word.
module eth_rx_filter_pack #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  input  logic [47:0] mac_addr,
  input  logic        promisc,
  input  logic        accept_mcast,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_filtered,
  output logic [15:0] cnt_overflow
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, HDR, PASS, DROP, TRUNC
  } state_t;

  state_t state, nxt;

  logic        vb;
  logic [2:0]  idx;
  logic [1:0]  lane;
  logic [31:0] acc, hold, word;
  logic        uc_r, bc_r, mc_r;
  logic        uc_now, bc_now, mc_now;
  logic        first, accept, runt;
  logic [7:0]  da_ref;
  logic [3:0]  fill_keep;
  logic        tseen, skip, skip_nxt;

  logic        push, full, pop, wr_en;
  logic [31:0] w_data;
  logic [3:0]  w_keep;
  logic        w_last, w_user;
  logic        inc_ok, inc_filt, inc_ovf;

  logic [37:0]   mem [DEPTH];
  logic [37:0]   rd_word;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign vb    = s_axis_tvalid;
  assign first = (state == IDLE);
  assign runt  = (idx != 3'd7);

  always_comb begin
    case (idx)
      3'd1:    da_ref = mac_addr[39:32];
      3'd2:    da_ref = mac_addr[31:24];
      3'd3:    da_ref = mac_addr[23:16];
      3'd4:    da_ref = mac_addr[15:8];
      3'd5:    da_ref = mac_addr[7:0];
      default: da_ref = mac_addr[47:40];
    endcase
  end

  // DA match flags accumulate byte by byte; byte 0 starts them fresh
  assign uc_now = (first | uc_r) & (s_axis_tdata == da_ref);
  assign bc_now = (first | bc_r) & (s_axis_tdata == 8'hFF);
  assign mc_now = first ? s_axis_tdata[0] : mc_r;
  assign accept = promisc | uc_now | bc_now
                | (accept_mcast & mc_now);

  assign word = (lane == 2'd0) ? {24'h0, s_axis_tdata}
              : acc | ({24'h0, s_axis_tdata} << {lane, 3'b000});

  always_comb begin
    case (lane)
      2'd0:    fill_keep = 4'h1;
      2'd1:    fill_keep = 4'h3;
      2'd2:    fill_keep = 4'h7;
      default: fill_keep = 4'hF;
    endcase
  end

  assign pop   = m_axis_tvalid & m_axis_tready;
  assign full  = (count == (AW+1)'(DEPTH)) & ~pop;
  assign wr_en = push & ~full;

  assign skip_nxt = (vb & tseen) ? ~s_axis_tlast : skip;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (vb && !s_axis_tlast) nxt = HDR;
      HDR:
        if (vb) begin
          if (s_axis_tlast)     nxt = IDLE;
          else if (idx == 3'd5)
            nxt = !accept ? DROP : (full ? TRUNC : PASS);
        end
      PASS:
        if (vb && (s_axis_tlast || lane == 2'd3)) begin
          if (full)              nxt = TRUNC;
          else if (s_axis_tlast) nxt = IDLE;
        end
      DROP:
        if (vb && s_axis_tlast) nxt = IDLE;
      TRUNC:
        if (tseen && !full) nxt = skip_nxt ? DROP : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    w_data   = word;
    w_keep   = 4'hF;
    w_last   = 1'b0;
    w_user   = 1'b0;
    inc_ok   = 1'b0;
    inc_filt = 1'b0;
    inc_ovf  = 1'b0;
    unique case (state)
      IDLE: inc_filt = vb & s_axis_tlast;
      HDR:
        if (vb) begin
          if (s_axis_tlast) begin
            inc_filt = 1'b1;
          end else if (idx == 3'd5) begin
            if (accept) begin
              push    = 1'b1;
              w_data  = hold;
              inc_ovf = full;
            end else begin
              inc_filt = 1'b1;
            end
          end
        end
      PASS:
        if (vb) begin
          if (s_axis_tlast) begin
            push   = 1'b1;
            w_keep = fill_keep;
            w_last = 1'b1;
            w_user = s_axis_tuser | runt;
            if (full)      inc_ovf  = 1'b1;
            else if (runt) inc_filt = 1'b1;
            else           inc_ok   = ~s_axis_tuser;
          end else if (lane == 2'd3) begin
            push    = 1'b1;
            inc_ovf = full;
          end
        end
      TRUNC: begin
        // a frame starting behind the truncated one is lost whole
        inc_ovf = vb & tseen & ~skip;
        if (tseen) begin
          push   = 1'b1;
          w_data = 32'h0;
          w_keep = 4'h1;
          w_last = 1'b1;
          w_user = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= 3'd0;
      lane  <= 2'd0;
      acc   <= 32'h0;
      hold  <= 32'h0;
      uc_r  <= 1'b0;
      bc_r  <= 1'b0;
      mc_r  <= 1'b0;
      tseen <= 1'b0;
      skip  <= 1'b0;
    end else begin
      if (nxt == IDLE) begin
        idx  <= 3'd0;
        lane <= 2'd0;
      end else if (vb) begin
        idx  <= (idx == 3'd7) ? idx : idx + 3'd1;
        lane <= lane + 2'd1;
      end
      if (vb && (first || state == HDR || state == PASS))
        acc <= word;
      if (vb && state == HDR && idx == 3'd3)
        hold <= word;
      if (vb && (first || state == HDR)) begin
        uc_r <= uc_now;
        bc_r <= bc_now;
        mc_r <= mc_now;
      end
      if (state != TRUNC) begin
        tseen <= vb & s_axis_tlast;
        skip  <= 1'b0;
      end else begin
        if (vb && s_axis_tlast) tseen <= 1'b1;
        skip <= skip_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {w_user, w_last, w_keep, w_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en}
                     - {{AW{1'b0}}, pop};
    end
  end

  assign m_axis_tvalid = (count != '0);
  assign rd_word = m_axis_tvalid ? mem[rd_ptr] : 38'h0;
  assign {m_axis_tuser, m_axis_tlast,
          m_axis_tkeep, m_axis_tdata} = rd_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_ok       <= 16'h0;
      cnt_filtered <= 16'h0;
      cnt_overflow <= 16'h0;
    end else begin
      cnt_ok       <= cnt_ok + {15'h0, inc_ok};
      cnt_filtered <= cnt_filtered + {15'h0, inc_filt};
      cnt_overflow <= cnt_overflow + {15'h0, inc_ovf};
    end
  end

endmodule

// File: tb/tb_eth_rx_filter_pack.sv
// tb_eth_rx_filter_pack: directed frames against a frame-level model
// of filtering, packing and overflow truncation.
module tb_eth_rx_filter_pack;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tuser;
  logic [47:0] mac;
  logic        promisc, accept_mcast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [15:0] cnt_ok, cnt_filtered, cnt_overflow;

  always #4 clk = ~clk;

  eth_rx_filter_pack #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .mac_addr(mac), .promisc(promisc), .accept_mcast(accept_mcast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .cnt_ok(cnt_ok), .cnt_filtered(cnt_filtered),
    .cnt_overflow(cnt_overflow)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } word_t;

  word_t       expq[$];
  word_t       cur;
  logic [7:0]  frm[$];
  int          nchk = 0, nerr = 0;
  int          exp_ok = 0, exp_filt = 0, exp_ovf = 0;
  int          rx_words = 0;
  logic [31:0] first_data, hold_data;
  logic [3:0]  last_keep;
  logic        last_user;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (expq.size() == 0) begin
        check("extra_word", {32'h0, m_tdata}, 64'h0);
      end else begin
        cur = expq.pop_front();
        check("word_data", {32'h0, m_tdata & kmask(cur.k)},
              {32'h0, cur.d & kmask(cur.k)});
        check("word_keep", {60'h0, m_tkeep}, {60'h0, cur.k});
        check("word_last", {63'h0, m_tlast}, {63'h0, cur.l});
        check("word_user", {63'h0, m_tuser}, {63'h0, cur.u});
      end
      if (rx_words == 0) first_data = m_tdata;
      rx_words++;
      last_keep = m_tkeep;
      last_user = m_tuser;
    end
  end

  task automatic mk_frame(input logic [47:0] da, input int len);
    frm.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6) frm.push_back(da[47-8*i -: 8]);
      else       frm.push_back(8'(i * 7 + 3));
    end
  endtask

  // Expected words and counter effects of the frame in frm, given the
  // number of free FIFO words when it arrives.
  task automatic model(input logic user, input int space);
    int n, nw;
    logic [47:0] da;
    logic ok;
    word_t w;
    n = frm.size();
    if (n <= 6) begin
      exp_filt++;
      return;
    end
    da = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
    ok = promisc || da == mac || da == 48'hFFFF_FFFF_FFFF
         || (accept_mcast && da[40]);
    if (!ok) begin
      exp_filt++;
      return;
    end
    nw = (n + 3) / 4;
    for (int j = 0; j < nw && j < space; j++) begin
      w = '0;
      for (int b = 0; b < 4; b++)
        if (4*j + b < n) begin
          w.d[8*b +: 8] = frm[4*j + b];
          w.k[b] = 1'b1;
        end
      if (j == nw - 1) begin
        w.l = 1'b1;
        w.u = user || n == 7;
      end
      expq.push_back(w);
    end
    if (nw > space) begin
      w = '0;
      w.k = 4'h1;
      w.l = 1'b1;
      w.u = 1'b1;
      expq.push_back(w);
      exp_ovf++;
    end else if (n == 7) begin
      exp_filt++;
    end else if (!user) begin
      exp_ok++;
    end
  endtask

  task automatic send(input logic user, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1;
      s_tdata  = frm[i];
      s_tlast  = (i == frm.size() - 1);
      s_tuser  = user && (i == frm.size() - 1);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic settle(input string tag);
    int t = 0;
    while (expq.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain"}, 64'(expq.size()), 64'h0);
    expq.delete();
    repeat (4) @(negedge clk);
    check({tag, "_cnt_ok"}, {48'h0, cnt_ok}, 64'(exp_ok & 16'hFFFF));
    check({tag, "_cnt_filt"}, {48'h0, cnt_filtered},
          64'(exp_filt & 16'hFFFF));
    check({tag, "_cnt_ovf"}, {48'h0, cnt_overflow},
          64'(exp_ovf & 16'hFFFF));
  endtask

  task automatic run(input string tag, input logic [47:0] da,
                     input int len, input logic user);
    mk_frame(da, len);
    model(user, DEPTH);
    rx_words = 0;
    send(user, len);
    settle(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    s_tdata = 8'h0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
    mac = 48'h02_00_00_00_00_01;
    promisc = 1'b0;
    accept_mcast = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", {63'h0, m_tvalid}, 64'h0);
    check("rst_tdata", {32'h0, m_tdata}, 64'h0);
    check("rst_tkeep", {60'h0, m_tkeep}, 64'h0);
    check("rst_tlast", {63'h0, m_tlast}, 64'h0);
    check("rst_tuser", {63'h0, m_tuser}, 64'h0);
    check("rst_cnts", {16'h0, cnt_ok, cnt_filtered, cnt_overflow}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run("uc", mac, 64, 1'b0);
    check("uc_words", 64'(rx_words), 64'd16);
    check("uc_first", {32'h0, first_data}, 64'h0000_0002);
    check("uc_lastkeep", {60'h0, last_keep}, 64'hF);
    check("uc_lastuser", {63'h0, last_user}, 64'h0);
    check("uc_ok_lit", {48'h0, cnt_ok}, 64'd1);

    run("miss", 48'h02_00_00_00_00_02, 64, 1'b0);
    check("miss_words", 64'(rx_words), 64'd0);
    check("miss_filt_lit", {48'h0, cnt_filtered}, 64'd1);

    promisc = 1'b1;
    run("promisc", 48'h02_00_00_00_00_02, 64, 1'b0);
    check("promisc_words", 64'(rx_words), 64'd16);
    promisc = 1'b0;

    run("bcast", 48'hFF_FF_FF_FF_FF_FF, 64, 1'b0);
    check("bcast_words", 64'(rx_words), 64'd16);

    run("mc_off", 48'h01_00_5E_00_00_01, 64, 1'b0);
    check("mc_off_words", 64'(rx_words), 64'd0);
    accept_mcast = 1'b1;
    run("mc_on", 48'h01_00_5E_00_00_01, 64, 1'b0);
    check("mc_on_words", 64'(rx_words), 64'd16);
    accept_mcast = 1'b0;

    run("odd65", mac, 65, 1'b0);
    check("odd65_words", 64'(rx_words), 64'd17);
    check("odd65_keep", {60'h0, last_keep}, 64'h1);
    run("odd67", mac, 67, 1'b0);
    check("odd67_keep", {60'h0, last_keep}, 64'h7);

    run("bad", mac, 64, 1'b1);
    check("bad_user", {63'h0, last_user}, 64'h1);
    check("bad_ok_lit", {48'h0, cnt_ok}, 64'd6);

    run("runt5", mac, 5, 1'b0);
    check("runt5_words", 64'(rx_words), 64'd0);
    run("runt7", mac, 7, 1'b0);
    check("runt7_words", 64'(rx_words), 64'd2);
    check("runt7_keep", {60'h0, last_keep}, 64'h7);
    check("runt7_user", {63'h0, last_user}, 64'h1);
    check("runt_filt_lit", {48'h0, cnt_filtered}, 64'd4);

    m_tready = 1'b0;
    mk_frame(mac, 300);
    model(1'b0, DEPTH);
    rx_words = 0;
    send(1'b0, 300);
    repeat (5) @(negedge clk);
    check("ovf_cnt_lit", {48'h0, cnt_overflow}, 64'd1);
    check("ovf_tvalid", {63'h0, m_tvalid}, 64'h1);
    hold_data = m_tdata;
    repeat (5) @(negedge clk);
    check("ovf_stall_hold", {32'h0, m_tdata}, {32'h0, hold_data});
    @(posedge clk); #1;
    m_tready = 1'b1;
    settle("ovf");
    check("ovf_words", 64'(rx_words), 64'd65);
    check("ovf_term_keep", {60'h0, last_keep}, 64'h1);
    check("ovf_term_user", {63'h0, last_user}, 64'h1);

    run("post_ovf", mac, 64, 1'b0);
    check("post_ovf_words", 64'(rx_words), 64'd16);

    m_tready = 1'b0;
    mk_frame(mac, 40);
    send(1'b0, 20);
    @(negedge clk);
    check("pre_rst_tvalid", {63'h0, m_tvalid}, 64'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete();
    exp_ok = 0;
    exp_filt = 0;
    exp_ovf = 0;
    @(negedge clk);
    check("mid_rst_tvalid", {63'h0, m_tvalid}, 64'h0);
    check("mid_rst_cnts", {16'h0, cnt_ok, cnt_filtered, cnt_overflow},
          64'h0);
    m_tready = 1'b1;
    run("post_rst", mac, 64, 1'b0);
    check("post_rst_words", 64'(rx_words), 64'd16);
    check("post_rst_ok_lit", {48'h0, cnt_ok}, 64'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
